// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one single-port memory between instruction fetch
// and the load/store unit. Only one bus transaction is in flight at a time.
// The LSU has priority, but after MAX_LS_STREAK consecutive LSU wins with
// fetch waiting, fetch is given the next slot so it cannot starve.
// Optional performance counters are enabled by defining RV32_ARB_PERF_EN.
module rv32i_mem_arbiter #(
    parameter int XLEN          = 32,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic            clk_in,
    input  logic            reset_in,
    input  logic            if_valid_in,
    input  logic [XLEN-1:0] if_addr_in,
    output logic            if_ready_o,
    input  logic            if_flush_in,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,
    input  logic            ls_valid_in,
    input  logic            ls_we_in,
    input  logic [3:0]      ls_be_in,
    input  logic [XLEN-1:0] ls_addr_in,
    input  logic [XLEN-1:0] ls_wdata_in,
    output logic            ls_ready_o,
    output logic            ls_rvalid_o,
    output logic [XLEN-1:0] ls_rdata_o,
    output logic            mem_req_o,
    input  logic            mem_gnt_in,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_rvalid_in,
    input  logic [XLEN-1:0] mem_rdata_in
`ifdef RV32_ARB_PERF_EN
    ,
    output logic [XLEN-1:0] perf_if_grants_o,
    output logic [XLEN-1:0] perf_ls_grants_o,
    output logic [XLEN-1:0] perf_conflict_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);
    localparam logic [3:0] STREAK_SAT = 4'hF;

    state_t          state_q, state_d;
    owner_t          owner_q, owner_d;
    logic            discard_q, discard_d;
    logic [3:0]      streak_q, streak_d;
    logic            req_d, we_d;
    logic [3:0]      be_d;
    logic [XLEN-1:0] addr_d, wdata_d;
    logic [XLEN-1:0] if_rdata_q, ls_rdata_q;

    logic ls_win, if_win;
    logic flush_hit, if_suppress;
    logic gnt_hit, rsp_hit;

    // Arbitration: LSU first unless fetch has waited through a full streak
    always_comb begin
        ls_win = ls_valid_in && !(if_valid_in && (streak_q == STREAK_MAX));
        if_win = if_valid_in && !ls_win;
    end

    // Handshake pulses; a flush kills the fetch pulse in the same cycle
    always_comb begin
        flush_hit   = if_flush_in && (owner_q == OWN_IF) && (state_q != S_IDLE);
        if_suppress = discard_q || flush_hit;
        gnt_hit     = (state_q == S_REQ)  && mem_gnt_in;
        rsp_hit     = (state_q == S_WAIT) && mem_rvalid_in;
        if_ready_o  = gnt_hit && (owner_q == OWN_IF) && !if_suppress;
        ls_ready_o  = gnt_hit && (owner_q == OWN_LS);
        if_rvalid_o = rsp_hit && (owner_q == OWN_IF) && !if_suppress;
        ls_rvalid_o = rsp_hit && (owner_q == OWN_LS);
        if_rdata_o  = if_rvalid_o ? mem_rdata_in : if_rdata_q;
        ls_rdata_o  = ls_rvalid_o ? mem_rdata_in : ls_rdata_q;
    end

    // Next-state and next bus-register values
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        discard_d = discard_q;
        streak_d  = streak_q;
        req_d     = mem_req_o;
        we_d      = mem_we_o;
        be_d      = mem_be_o;
        addr_d    = mem_addr_o;
        wdata_d   = mem_wdata_o;
        case (state_q)
            S_IDLE: begin
                if (ls_win) begin
                    owner_d = OWN_LS;
                    req_d   = 1'b1;
                    we_d    = ls_we_in;
                    be_d    = ls_be_in;
                    addr_d  = ls_addr_in;
                    wdata_d = ls_wdata_in;
                    state_d = S_REQ;
                    if (if_valid_in && (streak_q != STREAK_SAT))
                        streak_d = streak_q + 4'd1;
                end else if (if_win) begin
                    // Fetch is always a full-word read
                    owner_d  = OWN_IF;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    be_d     = 4'hF;
                    addr_d   = if_addr_in;
                    wdata_d  = '0;
                    streak_d = '0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (flush_hit) discard_d = 1'b1;
                if (mem_gnt_in) begin
                    req_d   = 1'b0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush_hit) discard_d = 1'b1;
                if (mem_rvalid_in) begin
                    discard_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, ownership and bus request registers
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            discard_q   <= 1'b0;
            streak_q    <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            discard_q   <= discard_d;
            streak_q    <= streak_d;
            mem_req_o   <= req_d;
            mem_we_o    <= we_d;
            mem_be_o    <= be_d;
            mem_addr_o  <= addr_d;
            mem_wdata_o <= wdata_d;
        end
    end

    // Each requester's read data holds until its own next response
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if (if_rvalid_o) if_rdata_q <= mem_rdata_in;
            if (ls_rvalid_o) ls_rdata_q <= mem_rdata_in;
        end
    end

`ifdef RV32_ARB_PERF_EN
    // Arbitration statistics, counted at the IDLE decision; wrap on overflow
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            perf_if_grants_o <= '0;
            perf_ls_grants_o <= '0;
            perf_conflict_o  <= '0;
        end else if (state_q == S_IDLE) begin
            if (if_win) perf_if_grants_o <= perf_if_grants_o + XLEN'(1);
            if (ls_win) perf_ls_grants_o <= perf_ls_grants_o + XLEN'(1);
            if (if_valid_in && ls_valid_in) perf_conflict_o <= perf_conflict_o + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Testbench for rv32i_mem_arbiter: directed scenarios plus randomized traffic
// scored against a transaction-level model of the arbitration rules.
module tb_rv32i_mem_arbiter;
    localparam int XLEN          = 32;
    localparam int MAX_LS_STREAK = 4;

    logic            clk, rst;
    logic            if_valid_in, if_ready_o, if_flush_in, if_rvalid_o;
    logic [XLEN-1:0] if_addr_in, if_rdata_o;
    logic            ls_valid_in, ls_we_in, ls_ready_o, ls_rvalid_o;
    logic [3:0]      ls_be_in;
    logic [XLEN-1:0] ls_addr_in, ls_wdata_in, ls_rdata_o;
    logic            mem_req_o, mem_gnt_in, mem_we_o, mem_rvalid_in;
    logic [3:0]      mem_be_o;
    logic [XLEN-1:0] mem_addr_o, mem_wdata_o, mem_rdata_in;
`ifdef RV32_ARB_PERF_EN
    logic [XLEN-1:0] perf_if_grants_o, perf_ls_grants_o, perf_conflict_o;
`endif

    rv32i_mem_arbiter #(.XLEN(XLEN), .MAX_LS_STREAK(MAX_LS_STREAK)) dut (
        .clk_in(clk), .reset_in(rst),
        .if_valid_in(if_valid_in), .if_addr_in(if_addr_in), .if_ready_o(if_ready_o),
        .if_flush_in(if_flush_in), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_valid_in(ls_valid_in), .ls_we_in(ls_we_in), .ls_be_in(ls_be_in),
        .ls_addr_in(ls_addr_in), .ls_wdata_in(ls_wdata_in), .ls_ready_o(ls_ready_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .mem_req_o(mem_req_o), .mem_gnt_in(mem_gnt_in), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in)
`ifdef RV32_ARB_PERF_EN
        , .perf_if_grants_o(perf_if_grants_o), .perf_ls_grants_o(perf_ls_grants_o),
        .perf_conflict_o(perf_conflict_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks, n_fails;

    // Memory contents and transaction-level model state
    logic [31:0] mem [0:63];
    int          streak_m;
    bit          inflight, granted, discard_m, own_ls, if_pend, ls_pend;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, last_if, last_ls;
    string       win_log;
    int          cnt_if, cnt_ls, cnt_conf;

    task automatic do_reset();
        rst = 1'b1;
        if_valid_in = 0; if_addr_in = 0; if_flush_in = 0;
        ls_valid_in = 0; ls_we_in = 0; ls_be_in = 0; ls_addr_in = 0; ls_wdata_in = 0;
        mem_gnt_in = 0; mem_rvalid_in = 0; mem_rdata_in = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        inflight = 0; granted = 0; discard_m = 0; own_ls = 0; if_pend = 0; ls_pend = 0;
        streak_m = 0; last_if = 0; last_ls = 0; win_log = "";
        cnt_if = 0; cnt_ls = 0; cnt_conf = 0;
        exp_we = 0; exp_be = 0; exp_addr = 0; exp_wdata = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_valid_in = 1; ls_valid_in = 1; mem_gnt_in = 1; mem_rvalid_in = 1;
        if_addr_in = 32'h44; ls_addr_in = 32'h88; ls_we_in = 1; ls_be_in = 4'hF;
        ls_wdata_in = 32'h1234_5678; mem_rdata_in = 32'hCAFE_F00D; if_flush_in = 0;
        #3;
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_be_o, if_ready_o, ls_ready_o, if_rvalid_o, ls_rvalid_o} !== 10'b0) begin
            $display("FAIL reset_ctrl: got %b expected 0",
                     {mem_req_o, mem_we_o, mem_be_o, if_ready_o, ls_ready_o, if_rvalid_o, ls_rvalid_o});
            n_fails++;
        end
        @(posedge clk); #1;
        n_checks++;
        if ({mem_addr_o, mem_wdata_o, if_rdata_o, ls_rdata_o, mem_req_o, if_ready_o, ls_ready_o} !== 131'b0) begin
            $display("FAIL reset_data: addr %h wdata %h if_rdata %h ls_rdata %h req %b expected all 0",
                     mem_addr_o, mem_wdata_o, if_rdata_o, ls_rdata_o, mem_req_o);
            n_fails++;
        end
        do_reset();
    endtask

    task automatic test_fetch_only();
        do_reset();
        @(posedge clk); #1; if_valid_in = 1; if_addr_in = 32'h100;
        @(negedge clk);
        n_checks++;
        if ({mem_req_o, if_ready_o, if_rvalid_o} !== 3'b000) begin
            $display("FAIL fetch_idle: got %b expected 000", {mem_req_o, if_ready_o, if_rvalid_o}); n_fails++;
        end
        @(posedge clk); #1; mem_gnt_in = 1;
        @(negedge clk);
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, if_ready_o} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin
            $display("FAIL fetch_grant: req %b we %b addr %h ready %b expected 1 0 00000100 1",
                     mem_req_o, mem_we_o, mem_addr_o, if_ready_o); n_fails++;
        end
        @(posedge clk); #1; if_valid_in = 0; mem_gnt_in = 0; mem_rvalid_in = 1; mem_rdata_in = 32'h13;
        @(negedge clk);
        n_checks++;
        if ({mem_req_o, if_ready_o, if_rvalid_o, if_rdata_o} !== {3'b001, 32'h13}) begin
            $display("FAIL fetch_resp: req %b ready %b rvalid %b rdata %h expected 0 0 1 00000013",
                     mem_req_o, if_ready_o, if_rvalid_o, if_rdata_o); n_fails++;
        end
        @(posedge clk); #1; mem_rvalid_in = 0; mem_rdata_in = 32'hFFFF_FFFF;
        @(negedge clk);
        n_checks++;
        if ({if_rvalid_o, if_rdata_o} !== {1'b0, 32'h13}) begin
            $display("FAIL fetch_hold: rvalid %b rdata %h expected 0 00000013", if_rvalid_o, if_rdata_o); n_fails++;
        end
    endtask

    task automatic test_store();
        do_reset();
        @(posedge clk); #1;
        ls_valid_in = 1; ls_we_in = 1; ls_be_in = 4'b0011; ls_addr_in = 32'h2000; ls_wdata_in = 32'hDEAD_BEEF;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; mem_gnt_in = (i == 3);
            @(negedge clk);
            n_checks++;
            if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, ls_ready_o} !==
                {1'b1, 1'b1, 4'b0011, 32'h2000, 32'hDEAD_BEEF, (i == 3)}) begin
                $display("FAIL store_req%0d: req %b we %b be %b addr %h wdata %h ready %b",
                         i, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, ls_ready_o); n_fails++;
            end
        end
        @(posedge clk); #1; ls_valid_in = 0; mem_gnt_in = 0;
        @(negedge clk);
        n_checks++;
        if ({mem_req_o, ls_rvalid_o} !== 2'b00) begin
            $display("FAIL store_wait: req %b rvalid %b expected 0 0", mem_req_o, ls_rvalid_o); n_fails++;
        end
        @(posedge clk); #1; mem_rvalid_in = 1; mem_rdata_in = 32'h0;
        @(negedge clk);
        n_checks++;
        if ({ls_rvalid_o, ls_ready_o, if_rvalid_o} !== 3'b100) begin
            $display("FAIL store_ack: got %b expected 100", {ls_rvalid_o, ls_ready_o, if_rvalid_o}); n_fails++;
        end
        @(posedge clk); #1; mem_rvalid_in = 0;
    endtask

    // Randomized traffic: requesters, memory and flushes are all driven here,
    // and every cycle is scored against the arbitration/handshake rules.
    task automatic run_engine(input int cycles, input int p_if, input int p_ls, input int p_flush,
                              input int max_gnt, input int max_rsp);
        int gnt_wait, rsp_wait;
        bit ls_wins, supp, e_a, e_b;
        gnt_wait = 0; rsp_wait = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (!if_pend) begin
                if_pend    = int'($urandom_range(0, 99)) < p_if;
                if_addr_in = 32'($urandom_range(0, 63)) << 2;
            end
            if (!ls_pend) begin
                ls_pend     = int'($urandom_range(0, 99)) < p_ls;
                ls_we_in    = 1'($urandom_range(0, 1));
                ls_be_in    = ls_we_in ? 4'($urandom_range(1, 15)) : 4'hF;
                ls_addr_in  = 32'($urandom_range(0, 63)) << 2;
                ls_wdata_in = $urandom;
            end
            if_valid_in   = if_pend;
            ls_valid_in   = ls_pend;
            if_flush_in   = int'($urandom_range(0, 99)) < p_flush;
            mem_gnt_in    = inflight && !granted && gnt_wait == 0;
            mem_rvalid_in = inflight && granted && rsp_wait == 0;
            mem_rdata_in  = $urandom;
            if (mem_rvalid_in && !exp_we) mem_rdata_in = mem[exp_addr[7:2]];
            @(negedge clk);
            if (!inflight) begin
                n_checks++;
                if ({mem_req_o, if_ready_o, ls_ready_o, if_rvalid_o, ls_rvalid_o} !== 5'b0) begin
                    $display("FAIL idle_quiet c%0d: got %b expected 00000", c,
                             {mem_req_o, if_ready_o, ls_ready_o, if_rvalid_o, ls_rvalid_o}); n_fails++;
                end
                if (if_pend || ls_pend) begin
                    ls_wins = ls_pend && !(if_pend && streak_m == MAX_LS_STREAK);
                    if (if_pend && ls_pend) cnt_conf++;
                    if (ls_wins) begin
                        cnt_ls++;
                        if (if_pend) streak_m = (streak_m < 15) ? streak_m + 1 : 15;
                        exp_we = ls_we_in; exp_be = ls_be_in; exp_addr = ls_addr_in; exp_wdata = ls_wdata_in;
                    end else begin
                        cnt_if++;
                        streak_m = 0;
                        exp_we = 1'b0; exp_addr = if_addr_in;
                    end
                    own_ls = ls_wins; inflight = 1; granted = 0;
                    gnt_wait = $urandom_range(0, max_gnt);
                end
            end else if (!granted) begin
                supp = !own_ls && (discard_m || if_flush_in);
                e_a  = mem_gnt_in && !own_ls && !supp;
                e_b  = mem_gnt_in && own_ls;
                n_checks++;
                if ({mem_req_o, mem_we_o, mem_addr_o} !== {1'b1, exp_we, exp_addr} ||
                    (own_ls && {mem_be_o, mem_wdata_o} !== {exp_be, exp_wdata})) begin
                    $display("FAIL req_fields c%0d: req %b we %b addr %h be %b wdata %h expected 1 %b %h %b %h",
                             c, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
                             exp_we, exp_addr, exp_be, exp_wdata); n_fails++;
                end
                n_checks++;
                if ({if_ready_o, ls_ready_o, if_rvalid_o, ls_rvalid_o} !== {e_a, e_b, 2'b00}) begin
                    $display("FAIL req_pulses c%0d: got %b expected %b", c,
                             {if_ready_o, ls_ready_o, if_rvalid_o, ls_rvalid_o}, {e_a, e_b, 2'b00}); n_fails++;
                end
                if (if_ready_o) win_log = {win_log, "I"};
                if (ls_ready_o) win_log = {win_log, "L"};
                if (!own_ls && if_flush_in) discard_m = 1;
                if (mem_gnt_in) begin
                    granted = 1;
                    rsp_wait = $urandom_range(0, max_rsp);
                    if (e_a) if_pend = 0;
                    if (e_b) ls_pend = 0;
                end else gnt_wait--;
            end else begin
                supp = !own_ls && (discard_m || if_flush_in);
                e_a  = mem_rvalid_in && !own_ls && !supp;
                e_b  = mem_rvalid_in && own_ls;
                n_checks++;
                if ({mem_req_o, if_ready_o, ls_ready_o, if_rvalid_o, ls_rvalid_o} !== {3'b000, e_a, e_b}) begin
                    $display("FAIL wait_pulses c%0d: got %b expected %b", c,
                             {mem_req_o, if_ready_o, ls_ready_o, if_rvalid_o, ls_rvalid_o}, {3'b000, e_a, e_b});
                    n_fails++;
                end
                if (e_a) last_if = mem_rdata_in;
                if (e_b) last_ls = mem_rdata_in;
                if (mem_rvalid_in) begin
                    if (own_ls && exp_we)
                        for (int b = 0; b < 4; b++)
                            if (exp_be[b]) mem[exp_addr[7:2]][8*b +: 8] = exp_wdata[8*b +: 8];
                    inflight = 0; discard_m = 0;
                end else begin
                    if (!own_ls && if_flush_in) discard_m = 1;
                    rsp_wait--;
                end
            end
            n_checks++;
            if ({if_rdata_o, ls_rdata_o} !== {last_if, last_ls}) begin
                $display("FAIL rdata c%0d: if %h ls %h expected %h %h", c, if_rdata_o, ls_rdata_o, last_if, last_ls);
                n_fails++;
            end
        end
        if_flush_in = 0;
    endtask

    task automatic test_contention();
        do_reset();
        run_engine(40, 100, 100, 0, 0, 0);
        n_checks++;
        if (win_log.len() != 13 || win_log.substr(0, 9) != "LLLLILLLLI") begin
            $display("FAIL contention_order: got %s expected LLLLILLLLILLL", win_log); n_fails++;
        end
    endtask

    task automatic test_flush();
        do_reset();
        @(posedge clk); #1; if_valid_in = 1; if_addr_in = 32'h40;
        @(posedge clk); #1; mem_gnt_in = 1;
        @(negedge clk);
        n_checks++;
        if ({if_ready_o, mem_addr_o} !== {1'b1, 32'h40}) begin
            $display("FAIL flush_grant: ready %b addr %h expected 1 00000040", if_ready_o, mem_addr_o); n_fails++;
        end
        @(posedge clk); #1; if_valid_in = 0; mem_gnt_in = 0; if_flush_in = 1;
        @(negedge clk);
        @(posedge clk); #1; if_flush_in = 0; mem_rvalid_in = 1; mem_rdata_in = 32'hBAD0_BAD0;
        @(negedge clk);
        n_checks++;
        if ({if_rvalid_o, if_rdata_o} !== {1'b0, 32'h0}) begin
            $display("FAIL flush_drop: rvalid %b rdata %h expected 0 00000000", if_rvalid_o, if_rdata_o); n_fails++;
        end
        @(posedge clk); #1; mem_rvalid_in = 0; if_valid_in = 1; if_addr_in = 32'h80;
        @(posedge clk); #1; mem_gnt_in = 1;
        @(negedge clk);
        n_checks++;
        if ({if_ready_o, mem_addr_o} !== {1'b1, 32'h80}) begin
            $display("FAIL flush_next_grant: ready %b addr %h expected 1 00000080", if_ready_o, mem_addr_o); n_fails++;
        end
        @(posedge clk); #1; if_valid_in = 0; mem_gnt_in = 0; mem_rvalid_in = 1; mem_rdata_in = 32'h0000_1234;
        @(negedge clk);
        n_checks++;
        if ({if_rvalid_o, if_rdata_o} !== {1'b1, 32'h1234}) begin
            $display("FAIL flush_next_resp: rvalid %b rdata %h expected 1 00001234", if_rvalid_o, if_rdata_o); n_fails++;
        end
        @(posedge clk); #1; mem_rvalid_in = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge clk); #1; ls_valid_in = 1; ls_we_in = 0; ls_be_in = 4'hF; ls_addr_in = 32'h20;
        @(posedge clk); #1; mem_gnt_in = 1;
        @(posedge clk); #1; ls_valid_in = 0; mem_gnt_in = 0;
        @(negedge clk); #2; rst = 1; mem_rvalid_in = 1; mem_rdata_in = 32'h5555_AAAA; #1;
        n_checks++;
        if ({mem_req_o, mem_addr_o, ls_rvalid_o, ls_ready_o, ls_rdata_o} !== 67'b0) begin
            $display("FAIL reset_mid: req %b addr %h rvalid %b rdata %h expected all 0",
                     mem_req_o, mem_addr_o, ls_rvalid_o, ls_rdata_o); n_fails++;
        end
        @(negedge clk); rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; mem_rvalid_in = 1;
            @(negedge clk);
            n_checks++;
            if ({mem_req_o, if_rvalid_o, ls_rvalid_o, if_ready_o, ls_ready_o} !== 5'b0) begin
                $display("FAIL reset_release%0d: got %b expected 00000", i,
                         {mem_req_o, if_rvalid_o, ls_rvalid_o, if_ready_o, ls_ready_o}); n_fails++;
            end
        end
        mem_rvalid_in = 0;
    endtask

    task automatic test_random();
        do_reset();
        run_engine(1500, 60, 60, 10, 3, 3);
        run_engine(600, 90, 90, 35, 1, 2);
    endtask

`ifdef RV32_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        run_engine(40, 60, 60, 0, 1, 1);
        @(posedge clk); #1;
        n_checks++;
        if ({perf_if_grants_o, perf_ls_grants_o, perf_conflict_o} !== {32'(cnt_if), 32'(cnt_ls), 32'(cnt_conf)}) begin
            $display("FAIL perf: if %0d ls %0d conf %0d expected %0d %0d %0d",
                     perf_if_grants_o, perf_ls_grants_o, perf_conflict_o, cnt_if, cnt_ls, cnt_conf);
            n_fails++;
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_fails = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        test_reset();
        test_fetch_only();
        test_store();
        test_contention();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef RV32_ARB_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
